// File: rtl/instr_fetch_queue.sv
// Decoupled instruction-fetch front end: issues sequential fetches over a req/ack
// handshake, buffers {pc+4, instr} in a small circular FIFO and flushes on redirect.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_pc_i,
    output logic                   imem_req_o,
    output logic [31:0]            imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [31:0]            imem_data_i,
    output logic                   ifid_valid_o,
    output logic [31:0]            ifid_pc_plus4_o,
    output logic [31:0]            ifid_instr_o,
    input  logic                   ifid_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic [63:0]      entries [DEPTH];
    logic [63:0]      head;
    logic             push, pop;

    // Redirect overrides both queue operations in its cycle.
    assign pop  = (count != '0) & ifid_ready_i & ~redirect_i;
    assign push = imem_ack_i & (state == REQ) & ~redirect_i;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (redirect_i || (count < FULL)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    // Without an ack the old transaction is still in flight and must be drained.
                    state_next = imem_ack_i ? REQ : DROP;
                end else if (imem_ack_i) begin
                    state_next = (count_next < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_ack_i) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req_o  = (state == REQ) || (state == DROP);
        imem_addr_o = fetch_pc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if ((state == REQ) && imem_ack_i) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    // Storage carries no reset; the outputs are masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            entries[wr_ptr] <= {fetch_pc + 32'd4, imem_data_i};
        end
    end

    assign head            = entries[rd_ptr];
    assign ifid_valid_o    = (count != '0);
    assign ifid_pc_plus4_o = ifid_valid_o ? head[63:32] : 32'd0;
    assign ifid_instr_o    = ifid_valid_o ? head[31:0]  : 32'd0;
    assign count_o         = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a variable-latency memory model that
// returns instr == fetch address.
module tb_instr_fetch_queue;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_plus4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_ready_i;
    logic [2:0]  count_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // memory model state
    bit          txn_active = 0;
    logic [31:0] txn_addr = 0;
    int          txn_lat = 0;
    int          wait_cnt = 0;
    int          lat_min = 0;
    int          lat_max = 0;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .ifid_valid_o(ifid_valid_o), .ifid_pc_plus4_o(ifid_pc_plus4_o),
        .ifid_instr_o(ifid_instr_o), .ifid_ready_i(ifid_ready_i),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic mem_update();
        if (imem_ack_i) txn_active = 0;
        if (imem_req_o && !txn_active) begin
            txn_active = 1;
            txn_addr   = imem_addr_o;
            txn_lat    = int'($urandom_range(lat_max, lat_min));
            wait_cnt   = 0;
        end
        if (txn_active && wait_cnt == txn_lat) begin
            imem_ack_i  = 1'b1;
            imem_data_i = txn_addr;
        end else begin
            imem_ack_i  = 1'b0;
            imem_data_i = 32'hDEAD_BEEF;
            if (txn_active) wait_cnt++;
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
        cyc++;
        mem_update();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        redirect_i = 1'b0;
        redirect_pc_i = 32'd0;
        imem_ack_i = 1'b0;
        imem_data_i = 32'd0;
        ifid_ready_i = 1'b0;
        txn_active = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        redirect_i = 1'b0;
        redirect_pc_i = 32'd0;
        imem_ack_i = 1'b0;
        imem_data_i = 32'd0;
        ifid_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", imem_req_o); end
        vectors++; if (imem_addr_o !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", imem_addr_o); end
        vectors++; if (ifid_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", ifid_valid_o); end
        vectors++; if (ifid_pc_plus4_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc4 got %h exp 0", ifid_pc_plus4_o); end
        vectors++; if (ifid_instr_o !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h exp 0", ifid_instr_o); end
        vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count_o); end
        do_reset();
        vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_cycle0_req got %b exp 0", imem_req_o); end
        cycle();
        vectors++; if (imem_req_o !== 1'b1) begin miscompares++; $display("FAIL reset_cycle1_req got %b exp 1", imem_req_o); end
    endtask

    task automatic test_stream();
        do_reset();
        lat_min = 0; lat_max = 0;
        ifid_ready_i = 1'b1;
        cycle();
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin miscompares++; $display("FAIL stream_c1 got req=%b addr=%h exp req=1 addr=0", imem_req_o, imem_addr_o); end
        vectors++; if (ifid_valid_o !== 1'b0) begin miscompares++; $display("FAIL stream_c1_valid got %b exp 0", ifid_valid_o); end
        for (int k = 2; k <= 8; k++) begin
            cycle();
            vectors++; if (ifid_valid_o !== 1'b1) begin miscompares++; $display("FAIL stream_valid c=%0d got %b exp 1", k, ifid_valid_o); end
            vectors++; if (ifid_pc_plus4_o !== 32'(4*(k-1))) begin miscompares++; $display("FAIL stream_pc4 c=%0d got %h exp %h", k, ifid_pc_plus4_o, 32'(4*(k-1))); end
            vectors++; if (ifid_instr_o !== 32'(4*(k-2))) begin miscompares++; $display("FAIL stream_instr c=%0d got %h exp %h", k, ifid_instr_o, 32'(4*(k-2))); end
            vectors++; if (imem_addr_o !== 32'(4*(k-1)) || count_o !== 3'd1) begin miscompares++; $display("FAIL stream_addr_count c=%0d got addr=%h count=%0d exp addr=%h count=1", k, imem_addr_o, count_o, 32'(4*(k-1))); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        do_reset();
        lat_min = 0; lat_max = 0;
        ifid_ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            vectors++; if (count_o !== 3'(k-1) || imem_addr_o !== 32'(4*(k-1)) || imem_req_o !== 1'b1) begin miscompares++; $display("FAIL stall_fill c=%0d got count=%0d addr=%h req=%b exp count=%0d addr=%h req=1", k, count_o, imem_addr_o, imem_req_o, k-1, 32'(4*(k-1))); end
        end
        for (int k = 5; k <= 6; k++) begin
            cycle();
            vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL stall_full_count c=%0d got %0d exp 4", k, count_o); end
            vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL stall_full_req c=%0d got %b exp 0", k, imem_req_o); end
            vectors++; if (imem_addr_o !== 32'h10) begin miscompares++; $display("FAIL stall_full_addr c=%0d got %h exp 10", k, imem_addr_o); end
        end
        vectors++; if (ifid_instr_o !== 32'h0 || ifid_pc_plus4_o !== 32'h4) begin miscompares++; $display("FAIL stall_head got instr=%h pc4=%h exp instr=0 pc4=4", ifid_instr_o, ifid_pc_plus4_o); end
        ifid_ready_i = 1'b1;
        cycle();
        vectors++; if (count_o !== 3'd3 || imem_req_o !== 1'b0 || ifid_instr_o !== 32'h4) begin miscompares++; $display("FAIL stall_c7 got count=%0d req=%b instr=%h exp count=3 req=0 instr=4", count_o, imem_req_o, ifid_instr_o); end
        cycle();
        vectors++; if (count_o !== 3'd2 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || ifid_instr_o !== 32'h8) begin miscompares++; $display("FAIL stall_c8 got count=%0d req=%b addr=%h instr=%h exp count=2 req=1 addr=10 instr=8", count_o, imem_req_o, imem_addr_o, ifid_instr_o); end
        exp = 32'hC;
        for (int k = 9; k <= 16; k++) begin
            cycle();
            vectors++; if (ifid_valid_o !== 1'b1 || ifid_instr_o !== exp || ifid_pc_plus4_o !== exp + 32'd4) begin miscompares++; $display("FAIL stall_drain c=%0d got valid=%b instr=%h pc4=%h exp instr=%h", k, ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o, exp); end
            exp = exp + 32'd4;
        end
    endtask

    task automatic test_redirect_latency();
        bit seen;
        do_reset();
        lat_min = 3; lat_max = 3;
        ifid_ready_i = 1'b0;
        repeat (9) cycle();
        vectors++; if (count_o !== 3'd2 || imem_addr_o !== 32'h8 || imem_req_o !== 1'b1) begin miscompares++; $display("FAIL rdlat_c9 got count=%0d addr=%h req=%b exp count=2 addr=8 req=1", count_o, imem_addr_o, imem_req_o); end
        cycle();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        cycle();
        redirect_i = 1'b0;
        vectors++; if (ifid_valid_o !== 1'b0 || count_o !== 3'd0) begin miscompares++; $display("FAIL rdlat_flush got valid=%b count=%0d exp valid=0 count=0", ifid_valid_o, count_o); end
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin miscompares++; $display("FAIL rdlat_drop got req=%b addr=%h exp req=1 addr=100", imem_req_o, imem_addr_o); end
        repeat (2) begin
            cycle();
            vectors++; if (ifid_valid_o !== 1'b0 || imem_addr_o !== 32'h100) begin miscompares++; $display("FAIL rdlat_discard c=%0d got valid=%b addr=%h exp valid=0 addr=100", cyc, ifid_valid_o, imem_addr_o); end
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (ifid_valid_o === 1'b1) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL rdlat_timeout got valid=0 exp valid=1 within 20 cycles");
        end else begin
            if (cyc !== 17 || ifid_pc_plus4_o !== 32'h104 || ifid_instr_o !== 32'h100) begin miscompares++; $display("FAIL rdlat_first got c=%0d pc4=%h instr=%h exp c=17 pc4=104 instr=100", cyc, ifid_pc_plus4_o, ifid_instr_o); end
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        lat_min = 0; lat_max = 0;
        ifid_ready_i = 1'b0;
        repeat (3) cycle();
        vectors++; if (count_o !== 3'd2 || imem_addr_o !== 32'h8) begin miscompares++; $display("FAIL rdack_c3 got count=%0d addr=%h exp count=2 addr=8", count_o, imem_addr_o); end
        redirect_i = 1'b1;
        redirect_pc_i = 32'h200;
        cycle();
        redirect_i = 1'b0;
        vectors++; if (count_o !== 3'd0 || ifid_valid_o !== 1'b0) begin miscompares++; $display("FAIL rdack_nopush got count=%0d valid=%b exp count=0 valid=0", count_o, ifid_valid_o); end
        vectors++; if (imem_addr_o !== 32'h200 || imem_req_o !== 1'b1) begin miscompares++; $display("FAIL rdack_addr got addr=%h req=%b exp addr=200 req=1", imem_addr_o, imem_req_o); end
        cycle();
        vectors++; if (count_o !== 3'd1 || ifid_pc_plus4_o !== 32'h204 || ifid_instr_o !== 32'h200 || imem_addr_o !== 32'h204) begin miscompares++; $display("FAIL rdack_target got count=%0d pc4=%h instr=%h addr=%h exp count=1 pc4=204 instr=200 addr=204", count_o, ifid_pc_plus4_o, ifid_instr_o, imem_addr_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        lat_min = 1; lat_max = 1;
        ifid_ready_i = 1'b0;
        repeat (7) cycle();
        vectors++; if (count_o !== 3'd3 || imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin miscompares++; $display("FAIL arst_pre got count=%0d req=%b addr=%h exp count=3 req=1 addr=C", count_o, imem_req_o, imem_addr_o); end
        #2;
        rst_i = 1'b1;
        #1;
        vectors++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) begin miscompares++; $display("FAIL arst_fetch got req=%b addr=%h exp req=0 addr=0", imem_req_o, imem_addr_o); end
        vectors++; if (ifid_valid_o !== 1'b0 || ifid_pc_plus4_o !== 32'h0 || ifid_instr_o !== 32'h0 || count_o !== 3'd0) begin miscompares++; $display("FAIL arst_queue got valid=%b pc4=%h instr=%h count=%0d exp all 0", ifid_valid_o, ifid_pc_plus4_o, ifid_instr_o, count_o); end
        do_reset();
        lat_min = 0; lat_max = 0;
        ifid_ready_i = 1'b1;
        cycle();
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin miscompares++; $display("FAIL arst_restart got req=%b addr=%h exp req=1 addr=0", imem_req_o, imem_addr_o); end
        cycle();
        vectors++; if (ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h0 || ifid_pc_plus4_o !== 32'h4) begin miscompares++; $display("FAIL arst_first got valid=%b instr=%h pc4=%h exp valid=1 instr=0 pc4=4", ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        int pops;
        do_reset();
        lat_min = 0; lat_max = 3;
        exp = 32'h0;
        pops = 0;
        for (int i = 0; i < 400 && pops < 20; i++) begin
            cycle();
            vectors++; if (count_o > 3'd4) begin miscompares++; $display("FAIL wrap_count c=%0d got %0d exp <=4", cyc, count_o); end
            ifid_ready_i = ($urandom_range(1, 0) == 1);
            if (ifid_valid_o === 1'b1 && ifid_ready_i) begin
                vectors++; if (ifid_instr_o !== exp || ifid_pc_plus4_o !== exp + 32'd4) begin miscompares++; $display("FAIL wrap_order pop=%0d got instr=%h pc4=%h exp instr=%h pc4=%h", pops, ifid_instr_o, ifid_pc_plus4_o, exp, exp + 32'd4); end
                exp = exp + 32'd4;
                pops++;
            end
        end
        vectors++; if (pops != 20) begin miscompares++; $display("FAIL wrap_timeout got %0d pops exp 20", pops); end
        ifid_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_latency();
        test_redirect_ack();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion exp finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
